// File: rtl/ysyx_23060203_pkg.sv
`default_nettype none
// ysyx_23060203_pkg: shared register-address type and validity helper for the
// register file and its scoreboard.
package ysyx_23060203_pkg;

    localparam int REG_AW = 5;

    typedef logic [REG_AW-1:0] reg_addr_t;

    // x0 and anything beyond the implemented register count never hold state.
    function automatic logic reg_valid(input reg_addr_t addr, input int unsigned nr_reg);
        return (addr != '0) && (32'(addr) < nr_reg);
    endfunction

endpackage
`default_nettype wire

// File: rtl/ysyx_23060203_regfile_sb_if.sv
`default_nettype none
// ysyx_23060203_regfile_sb_if: read, issue-claim and writeback bundle of the
// scoreboarded register file; master = pipeline side, slave = register file.
interface ysyx_23060203_regfile_sb_if
    import ysyx_23060203_pkg::*;
#(
    parameter int NR_RD = 2,
    parameter int NR_WR = 2,
    parameter int XLEN  = 32,
    parameter int TAG_W = 4
);

    logic [NR_RD*REG_AW-1:0] raddr;
    logic [NR_RD*XLEN-1:0]   rdata;
    logic [NR_RD-1:0]        rbusy;

    logic                    iss_valid;
    reg_addr_t               iss_rd;
    logic [TAG_W-1:0]        iss_tag;

    logic [NR_WR-1:0]        wen;
    logic [NR_WR*REG_AW-1:0] waddr;
    logic [NR_WR*XLEN-1:0]   wdata;
    logic [NR_WR*TAG_W-1:0]  wtag;

    logic                    flush;

    modport master (
        output raddr, iss_valid, iss_rd, iss_tag, wen, waddr, wdata, wtag, flush,
        input  rdata, rbusy
    );

    modport slave (
        input  raddr, iss_valid, iss_rd, iss_tag, wen, waddr, wdata, wtag, flush,
        output rdata, rbusy
    );

endinterface
`default_nettype wire

// File: rtl/ysyx_23060203_sb_entry.sv
`default_nettype none
// ysyx_23060203_sb_entry: busy bit and owner tag of one register, resolving
// claim > flush > release priority.
module ysyx_23060203_sb_entry #(
    parameter int TAG_W = 4,
    parameter int NR_WR = 2
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   claim_i,
    input  logic [TAG_W-1:0]       iss_tag_i,
    input  logic [NR_WR-1:0]       hit_i,
    input  logic [NR_WR*TAG_W-1:0] wtag_i,
    input  logic                   flush_i,
    output logic                   busy_o,
    output logic                   release_o
);

    logic             busy_q, busy_d;
    logic [TAG_W-1:0] owner_q, owner_d;
    logic             release_w;

    // Only the current owner's writeback clears busy; stale producers do not.
    always_comb begin
        release_w = 1'b0;
        for (int j = 0; j < NR_WR; j++) begin
            if (hit_i[j] && (wtag_i[j*TAG_W +: TAG_W] == owner_q)) begin
                release_w = 1'b1;
            end
        end
    end

    always_comb begin
        busy_d  = busy_q;
        owner_d = owner_q;
        if (claim_i) begin
            busy_d  = 1'b1;
            owner_d = iss_tag_i;
        end else if (flush_i || release_w) begin
            busy_d  = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            busy_q  <= 1'b0;
            owner_q <= '0;
        end else begin
            busy_q  <= busy_d;
            owner_q <= owner_d;
        end
    end

    assign busy_o    = busy_q;
    assign release_o = release_w;

endmodule
`default_nettype wire

// File: rtl/ysyx_23060203_regfile_sb.sv
`default_nettype none
// ysyx_23060203_regfile_sb: multi-port GPR file with same-cycle write bypass
// and a per-register tagged scoreboard for RAW hazard tracking.
module ysyx_23060203_regfile_sb
    import ysyx_23060203_pkg::*;
#(
    parameter int NR_REG = 16,
    parameter int XLEN   = 32,
    parameter int NR_RD  = 2,
    parameter int NR_WR  = 2,
    parameter int TAG_W  = 4,
    parameter bit BYPASS = 1'b1
) (
    input logic                        clock,
    input logic                        reset,
    ysyx_23060203_regfile_sb_if.slave  bus
);

    logic [XLEN-1:0]   regs_q [NR_REG];
    logic [XLEN-1:0]   regs_d [NR_REG];
    logic [NR_REG-1:0] busy_w;
    logic [NR_REG-1:0] release_w;

    // Ascending port order lets the highest-indexed port win a collision.
    always_comb begin
        for (int k = 0; k < NR_REG; k++) begin
            regs_d[k] = regs_q[k];
        end
        for (int j = 0; j < NR_WR; j++) begin
            if (bus.wen[j] && reg_valid(bus.waddr[j*REG_AW +: REG_AW], NR_REG)) begin
                for (int k = 0; k < NR_REG; k++) begin
                    if (bus.waddr[j*REG_AW +: REG_AW] == REG_AW'(k)) begin
                        regs_d[k] = bus.wdata[j*XLEN +: XLEN];
                    end
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < NR_REG; k++) begin
                regs_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < NR_REG; k++) begin
                regs_q[k] <= regs_d[k];
            end
        end
    end

    assign busy_w[0]    = 1'b0;
    assign release_w[0] = 1'b0;

    for (genvar k = 1; k < NR_REG; k++) begin : g_entry
        logic [NR_WR-1:0] hit;
        logic             claim;

        always_comb begin
            for (int j = 0; j < NR_WR; j++) begin
                hit[j] = bus.wen[j] && (bus.waddr[j*REG_AW +: REG_AW] == REG_AW'(k));
            end
        end

        assign claim = bus.iss_valid && (bus.iss_rd == REG_AW'(k));

        ysyx_23060203_sb_entry #(
            .TAG_W (TAG_W),
            .NR_WR (NR_WR)
        ) u_entry (
            .clock     (clock),
            .reset     (reset),
            .claim_i   (claim),
            .iss_tag_i (bus.iss_tag),
            .hit_i     (hit),
            .wtag_i    (bus.wtag),
            .flush_i   (bus.flush),
            .busy_o    (busy_w[k]),
            .release_o (release_w[k])
        );
    end

    for (genvar i = 0; i < NR_RD; i++) begin : g_rd
        reg_addr_t       addr;
        logic            valid;
        logic [XLEN-1:0] data;
        logic            busy;

        assign addr  = bus.raddr[i*REG_AW +: REG_AW];
        assign valid = reg_valid(addr, NR_REG);

        always_comb begin
            data = '0;
            busy = 1'b0;
            if (valid) begin
                for (int k = 0; k < NR_REG; k++) begin
                    if (addr == REG_AW'(k)) begin
                        data = regs_q[k];
                        busy = busy_w[k] & ~(BYPASS & release_w[k]);
                    end
                end
                if (BYPASS) begin
                    for (int j = 0; j < NR_WR; j++) begin
                        if (bus.wen[j] && (bus.waddr[j*REG_AW +: REG_AW] == addr)) begin
                            data = bus.wdata[j*XLEN +: XLEN];
                        end
                    end
                end
            end
        end

        assign bus.rdata[i*XLEN +: XLEN] = data;
        assign bus.rbusy[i]              = busy;
    end

endmodule
`default_nettype wire
